// File: rtl/sr_flag_arbiter.sv
// Round-robin arbiter granting one set/clear op per cycle onto a shared SR flag bank,
// with an optional per-requester lock and timeout. Define SR_FLAG_TOGGLE_EN to add toggle ops.
module sr_flag_arbiter #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned NUM_FLAGS = 8,
    parameter int unsigned IDX_W     = 3,
    parameter int unsigned LOCK_MAX  = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ-1:0]       req_set,
    input  logic [NUM_REQ*IDX_W-1:0] req_idx,
    input  logic [NUM_REQ-1:0]       req_lock,
`ifdef SR_FLAG_TOGGLE_EN
    input  logic [NUM_REQ-1:0]       req_tgl,
`endif
    output logic [NUM_REQ-1:0]       ack,
    output logic                     err,
    output logic [NUM_FLAGS-1:0]     q,
    output logic [NUM_FLAGS-1:0]     qbar,
    output logic                     busy,
    output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] owner
);

    localparam int unsigned REQ_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CNT_W = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;

    typedef enum logic {
        S_IDLE,
        S_LOCKED
    } state_t;

    state_t               state_q, state_d;
    logic [REQ_W-1:0]     ptr_q, ptr_d;
    logic [REQ_W-1:0]     owner_q, owner_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [NUM_REQ-1:0]   ack_q, ack_d;
    logic                 err_q, err_d;
    logic [NUM_FLAGS-1:0] q_q, q_d;
    logic [NUM_FLAGS-1:0] qbar_q, qbar_d;
    logic                 busy_q, busy_d;

    logic [NUM_REQ-1:0]   elig;
    logic                 gnt_vld;
    logic [REQ_W-1:0]     gnt_id;
    logic [REQ_W-1:0]     cand;
    logic                 g_set;
    logic                 g_lock;
    logic                 g_tgl;
    logic [IDX_W-1:0]     g_idx;
    logic                 g_in_range;

    // Held requests are masked by their own ack; while locked only the owner competes.
    always_comb begin
        elig = req & ~ack_q;
        if (state_q == S_LOCKED) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (owner_q != REQ_W'(i)) begin
                    elig[i] = 1'b0;
                end
            end
        end
    end

    // First eligible requester at or after ptr, wrapping.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_id  = '0;
        cand    = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = REQ_W'((32'(ptr_q) + k) % NUM_REQ);
            if (!gnt_vld && elig[cand]) begin
                gnt_vld = 1'b1;
                gnt_id  = cand;
            end
        end
    end

    always_comb begin
        g_set      = req_set[gnt_id];
        g_lock     = req_lock[gnt_id];
        g_idx      = req_idx[32'(gnt_id)*IDX_W +: IDX_W];
        g_in_range = (32'(g_idx) < NUM_FLAGS);
`ifdef SR_FLAG_TOGGLE_EN
        g_tgl      = req_tgl[gnt_id];
`else
        g_tgl      = 1'b0;
`endif
    end

    // Next-state, flag update and registered outputs.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        ack_d   = '0;
        err_d   = 1'b0;
        q_d     = q_q;

        if (gnt_vld) begin
            err_d = !g_in_range;
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (gnt_id == REQ_W'(i)) begin
                    ack_d[i] = 1'b1;
                end
            end
            for (int unsigned f = 0; f < NUM_FLAGS; f++) begin
                if (g_in_range && (32'(g_idx) == f)) begin
                    q_d[f] = g_tgl ? ~q_q[f] : g_set;
                end
            end
        end

        case (state_q)
            S_IDLE: begin
                if (gnt_vld) begin
                    ptr_d = REQ_W'((32'(gnt_id) + 1) % NUM_REQ);
                    if (g_lock) begin
                        state_d = S_LOCKED;
                        owner_d = gnt_id;
                        cnt_d   = '0;
                    end
                end
            end
            S_LOCKED: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(LOCK_MAX - 1)) begin
                    state_d = S_IDLE;
                    owner_d = '0;
                    cnt_d   = '0;
                    ptr_d   = REQ_W'((32'(owner_q) + 1) % NUM_REQ);
                end else if (gnt_vld && !g_lock) begin
                    state_d = S_IDLE;
                    owner_d = '0;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                owner_d = '0;
                cnt_d   = '0;
            end
        endcase

        qbar_d = ~q_d;
        busy_d = (state_d == S_LOCKED);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            cnt_q   <= '0;
            ack_q   <= '0;
            err_q   <= 1'b0;
            q_q     <= '0;
            qbar_q  <= '1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            q_q     <= q_d;
            qbar_q  <= qbar_d;
            busy_q  <= busy_d;
        end
    end

    assign ack   = ack_q;
    assign err   = err_q;
    assign q     = q_q;
    assign qbar  = qbar_q;
    assign busy  = busy_q;
    assign owner = owner_q;

endmodule

// File: tb/tb_sr_flag_arbiter.sv
// Scoreboard bench for sr_flag_arbiter (NUM_FLAGS=6, LOCK_MAX=4); toggle test under SR_FLAG_TOGGLE_EN.
module tb_sr_flag_arbiter;

    localparam int unsigned NR = 4;
    localparam int unsigned NF = 6;
    localparam int unsigned IW = 3;
    localparam int unsigned LM = 4;
    localparam int unsigned RW = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NR-1:0]     req, req_set, req_lock;
    logic [NR*IW-1:0]  req_idx;
`ifdef SR_FLAG_TOGGLE_EN
    logic [NR-1:0]     req_tgl;
`endif
    logic [NR-1:0]     ack;
    logic              err;
    logic [NF-1:0]     q, qbar;
    logic              busy;
    logic [RW-1:0]     owner;

    sr_flag_arbiter #(
        .NUM_REQ(NR), .NUM_FLAGS(NF), .IDX_W(IW), .LOCK_MAX(LM)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req(req), .req_set(req_set), .req_idx(req_idx), .req_lock(req_lock),
`ifdef SR_FLAG_TOGGLE_EN
        .req_tgl(req_tgl),
`endif
        .ack(ack), .err(err), .q(q), .qbar(qbar), .busy(busy), .owner(owner)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NR-1:0] ack;
        logic          err;
        logic [NF-1:0] q;
        logic          busy;
        logic [RW-1:0] owner;
    } exp_t;

    exp_t sb[$];
    int   n_run  = 0;
    int   n_fail = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Push the expected post-edge outputs, advance one edge, pop and compare.
    task automatic step(input string tag, input logic [NR-1:0] a, input logic e,
                        input logic [NF-1:0] qv, input logic b, input logic [RW-1:0] o);
        exp_t x;
        logic [NF-1:0] qb;
        x.ack = a; x.err = e; x.q = qv; x.busy = b; x.owner = o;
        sb.push_back(x);
        @(posedge clk);
        #1;
        x  = sb.pop_front();
        qb = ~x.q;
        check_val({tag, ".ack"},   32'(ack),   32'(x.ack));
        check_val({tag, ".err"},   32'(err),   32'(x.err));
        check_val({tag, ".q"},     32'(q),     32'(x.q));
        check_val({tag, ".qbar"},  32'(qbar),  32'(qb));
        check_val({tag, ".busy"},  32'(busy),  32'(x.busy));
        check_val({tag, ".owner"}, 32'(owner), 32'(x.owner));
    endtask

    task automatic put(input int i, input logic r, input logic s, input int idx, input logic l);
        req[i]              = r;
        req_set[i]          = s;
        req_idx[i*IW +: IW] = IW'(idx);
        req_lock[i]         = l;
    endtask

    task automatic clear_inputs();
        req = '0; req_set = '0; req_idx = '0; req_lock = '0;
`ifdef SR_FLAG_TOGGLE_EN
        req_tgl = '0;
`endif
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst.ack",   32'(ack),   32'h0);
        check_val("rst.err",   32'(err),   32'h0);
        check_val("rst.q",     32'(q),     32'h00);
        check_val("rst.qbar",  32'(qbar),  32'h3F);
        check_val("rst.busy",  32'(busy),  32'h0);
        check_val("rst.owner", 32'(owner), 32'h0);
        rst_n = 1'b1;

        // Single request: r1 sets flag 3, one-cycle ack pulse.
        put(1, 1'b1, 1'b1, 3, 1'b0);
        step("t1_grant", 4'b0010, 1'b0, 6'h08, 1'b0, 2'd0);
        put(1, 1'b0, 1'b0, 0, 1'b0);
        step("t1_idle",  4'b0000, 1'b0, 6'h08, 1'b0, 2'd0);

        // All four request at once from ptr=0: served strictly in order.
        do_reset();
        for (int i = 0; i < 4; i++) put(i, 1'b1, 1'b1, i, 1'b0);
        step("t2_r0", 4'b0001, 1'b0, 6'h01, 1'b0, 2'd0);
        put(0, 1'b0, 1'b0, 0, 1'b0);
        step("t2_r1", 4'b0010, 1'b0, 6'h03, 1'b0, 2'd0);
        put(1, 1'b0, 1'b0, 0, 1'b0);
        step("t2_r2", 4'b0100, 1'b0, 6'h07, 1'b0, 2'd0);
        put(2, 1'b0, 1'b0, 0, 1'b0);
        step("t2_r3", 4'b1000, 1'b0, 6'h0F, 1'b0, 2'd0);
        put(3, 1'b0, 1'b0, 0, 1'b0);
        step("t2_done", 4'b0000, 1'b0, 6'h0F, 1'b0, 2'd0);

        // r2 locks, r0 waits until r2 releases with a clear.
        put(2, 1'b1, 1'b1, 5, 1'b1);
        step("t3_lock", 4'b0100, 1'b0, 6'h2F, 1'b1, 2'd2);
        put(2, 1'b1, 1'b0, 5, 1'b0);
        put(0, 1'b1, 1'b1, 4, 1'b0);
        step("t3_wait", 4'b0000, 1'b0, 6'h2F, 1'b1, 2'd2);
        step("t3_unlk", 4'b0100, 1'b0, 6'h0F, 1'b0, 2'd0);
        put(2, 1'b0, 1'b0, 0, 1'b0);
        step("t3_r0",   4'b0001, 1'b0, 6'h1F, 1'b0, 2'd0);
        put(0, 1'b0, 1'b0, 0, 1'b0);

        // r1 locks then goes quiet; timeout releases after LOCK_MAX cycles, r3 then served.
        put(1, 1'b1, 1'b0, 0, 1'b1);
        step("t4_lock", 4'b0010, 1'b0, 6'h1E, 1'b1, 2'd1);
        put(1, 1'b0, 1'b0, 0, 1'b0);
        put(3, 1'b1, 1'b0, 1, 1'b0);
        for (int c = 1; c < int'(LM); c++) step("t4_held", 4'b0000, 1'b0, 6'h1E, 1'b1, 2'd1);
        step("t4_tmo",  4'b0000, 1'b0, 6'h1E, 1'b0, 2'd0);
        step("t4_r3",   4'b1000, 1'b0, 6'h1C, 1'b0, 2'd0);
        put(3, 1'b0, 1'b0, 0, 1'b0);

        // Out-of-range index: ack plus err, flags untouched.
        put(0, 1'b1, 1'b1, 7, 1'b0);
        step("t5_err",  4'b0001, 1'b1, 6'h1C, 1'b0, 2'd0);
        put(0, 1'b0, 1'b0, 0, 1'b0);
        step("t5_post", 4'b0000, 1'b0, 6'h1C, 1'b0, 2'd0);

        // Reset in the middle of a lock clears everything.
        put(2, 1'b1, 1'b1, 5, 1'b1);
        step("t5_lock", 4'b0100, 1'b0, 6'h3C, 1'b1, 2'd2);
        put(2, 1'b0, 1'b0, 0, 1'b0);
        put(3, 1'b1, 1'b1, 0, 1'b0);
        rst_n = 1'b0;
        step("t5_rst",  4'b0000, 1'b0, 6'h00, 1'b0, 2'd0);
        rst_n = 1'b1;
        clear_inputs();
        step("t5_quiet", 4'b0000, 1'b0, 6'h00, 1'b0, 2'd0);

`ifdef SR_FLAG_TOGGLE_EN
        // Toggle twice with req held (set bit ignored), then toggle out of range.
        do_reset();
        put(0, 1'b1, 1'b0, 2, 1'b0);
        req_tgl[0] = 1'b1;
        step("t6_tg1",  4'b0001, 1'b0, 6'h04, 1'b0, 2'd0);
        put(0, 1'b1, 1'b1, 2, 1'b0);
        step("t6_gap",  4'b0000, 1'b0, 6'h04, 1'b0, 2'd0);
        step("t6_tg2",  4'b0001, 1'b0, 6'h00, 1'b0, 2'd0);
        put(0, 1'b1, 1'b1, 6, 1'b0);
        step("t6_gap2", 4'b0000, 1'b0, 6'h00, 1'b0, 2'd0);
        step("t6_oor",  4'b0001, 1'b1, 6'h00, 1'b0, 2'd0);
        clear_inputs();
        step("t6_end",  4'b0000, 1'b0, 6'h00, 1'b0, 2'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
